// File: rtl/score_digit_mux.sv
// Two-digit BCD score keeper for left/right players with win detection, and a
// time-multiplexed digit select/value feed for the downstream seven-segment decoder.
module score_digit_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int WIN_SCORE   = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       score_l,
  input  logic       score_r,
  input  logic       clear,
  output logic [1:0] tog,
  output logic [3:0] num,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int            CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]    WIN     = 7'(WIN_SCORE);

  typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_t;

  state_t        state, state_nxt;
  logic          scl_p1, scr_p1, arm_p1, evl_p1, evr_p1;
  logic [7:0]    score_lq, score_rq;
  logic          hit_l, hit_r, frozen;
  logic [1:0]    winner_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    tog_nxt;
  logic [3:0]    dig;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bcd_val(input logic [7:0] v);
    return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
  endfunction

  function automatic logic [3:0] sat9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Stage p1: edge detect; arm_p1 keeps an input already high at reset release from counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_p1 <= 1'b0;
      scr_p1 <= 1'b0;
      arm_p1 <= 1'b0;
      evl_p1 <= 1'b0;
      evr_p1 <= 1'b0;
    end else begin
      scl_p1 <= score_l;
      scr_p1 <= score_r;
      arm_p1 <= 1'b1;
      evl_p1 <= arm_p1 & score_l & ~scl_p1 & ~clear;
      evr_p1 <= arm_p1 & score_r & ~scr_p1 & ~clear;
    end
  end

  assign hit_l  = (bcd_val(score_lq) == WIN);
  assign hit_r  = (bcd_val(score_rq) == WIN);
  // A score sitting at WIN_SCORE blocks further counting before the state catches up
  assign frozen = (state == OVER) | hit_l | hit_r;

  // Stage p2: score registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_lq <= 8'h00;
      score_rq <= 8'h00;
    end else if (clear) begin
      score_lq <= 8'h00;
      score_rq <= 8'h00;
    end else if (!frozen) begin
      if (evl_p1) score_lq <= bcd_inc(score_lq);
      if (evr_p1) score_rq <= bcd_inc(score_rq);
    end
  end

  always_comb begin
    state_nxt  = state;
    winner_nxt = winner;
    case (state)
      PLAY: if ((hit_l | hit_r) && !clear) begin
        state_nxt  = OVER;
        winner_nxt = {hit_r, hit_l};
      end
      OVER: if (!hit_l && !hit_r) begin
        state_nxt  = PLAY;
        winner_nxt = 2'b00;
      end
      default: state_nxt = PLAY;
    endcase
  end

  // Stage p3: game state, flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PLAY;
      winner    <= 2'b00;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      winner    <= winner_nxt;
      game_over <= (state_nxt == OVER);
    end
  end

  assign tog_nxt = (cnt == CNT_MAX) ? tog + 2'd1 : tog;

  always_comb begin
    dig = 4'd0;
    case (tog_nxt)
      2'd0: dig = score_rq[3:0];
      2'd1: dig = score_rq[7:4];
      2'd2: dig = score_lq[3:0];
      2'd3: dig = score_lq[7:4];
      default: dig = 4'd0;
    endcase
  end

  // Display stage: num follows the next digit select so both change on one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      tog <= 2'd0;
      num <= 4'd0;
    end else begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
      tog <= tog_nxt;
      num <= sat9(dig);
    end
  end

endmodule

// File: tb/tb_score_digit_mux.sv
// Bench for score_digit_mux: integer-score reference model compared every cycle,
// plus directed scenarios with hand-computed display and win expectations.
module tb_score_digit_mux;

  localparam int DIV = 4;
  localparam int W   = 11;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       score_l = 1'b0, score_r = 1'b0, clear = 1'b0;
  logic [1:0] tog, winner;
  logic [3:0] num;
  logic       game_over;

  score_digit_mux #(.REFRESH_DIV(DIV), .WIN_SCORE(W)) dut (
    .clk(clk), .rst_n(rst_n), .score_l(score_l), .score_r(score_r), .clear(clear),
    .tog(tog), .num(num), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain integer scores, edges-since-reset counter for the scan
  int         m_k = 0, m_l = 0, m_r = 0;
  bit         m_over = 0, m_pl = 0, m_pr = 0, m_arm = 0, m_el = 0, m_er = 0;
  logic [1:0] m_win = 2'b00;
  logic [3:0] m_num = 4'd0;

  function automatic logic [3:0] digit_of(input int t, input int l, input int r);
    case (t)
      0: return 4'(r % 10);
      1: return 4'(r / 10);
      2: return 4'(l % 10);
      default: return 4'(l / 10);
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k <= 0; m_l <= 0; m_r <= 0; m_over <= 0; m_win <= 2'b00;
      m_pl <= 0; m_pr <= 0; m_arm <= 0; m_el <= 0; m_er <= 0; m_num <= 4'd0;
    end else begin
      m_k   <= m_k + 1;
      m_pl  <= score_l;
      m_pr  <= score_r;
      m_arm <= 1'b1;
      m_el  <= m_arm && score_l && !m_pl && !clear;
      m_er  <= m_arm && score_r && !m_pr && !clear;
      m_l   <= clear ? 0 : (!(m_over || m_l == W || m_r == W) && m_el) ? m_l + 1 : m_l;
      m_r   <= clear ? 0 : (!(m_over || m_l == W || m_r == W) && m_er) ? m_r + 1 : m_r;
      if (!m_over) begin
        if ((m_l == W || m_r == W) && !clear) begin
          m_over <= 1'b1;
          m_win  <= {m_r == W, m_l == W};
        end
      end else if (m_l != W && m_r != W) begin
        m_over <= 1'b0;
        m_win  <= 2'b00;
      end
      m_num <= digit_of(((m_k + 1) / DIV) % 4, m_l, m_r);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_tog", tog, (m_k / DIV) % 4);
      chk("cyc_num", num, m_num);
      chk("cyc_game_over", game_over, m_over);
      chk("cyc_winner", winner, m_win);
    end
  end

  task automatic pulse(input bit l, input bit r);
    @(negedge clk); score_l = l; score_r = r;
    @(negedge clk); score_l = 0; score_r = 0;
    @(negedge clk);
  endtask

  task automatic digit_check(input string nm, input int t, input int exp);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tog == 2'(t)) break;
    end
    chk({nm, "_tog"}, tog, t);
    chk(nm, num, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_tog", tog, 0);
    chk("rst_num", num, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_winner", winner, 0);

    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk); chk("scan_tog1", tog, 1); chk("scan_num1", num, 0);
    repeat (4) @(negedge clk); chk("scan_tog2", tog, 2);
    repeat (4) @(negedge clk); chk("scan_tog3", tog, 3);
    repeat (4) @(negedge clk); chk("scan_tog0", tog, 0);

    repeat (10) pulse(1, 0);
    repeat (2) @(negedge clk);
    chk("model_left10", m_l, 10);
    digit_check("l10_tens", 3, 1);
    digit_check("l10_ones", 2, 0);
    digit_check("l10_r_ones", 0, 0);
    digit_check("l10_r_tens", 1, 0);

    @(negedge clk); score_r = 1;
    repeat (20) @(negedge clk);
    score_r = 0;
    repeat (3) @(negedge clk);
    chk("model_right_hold", m_r, 1);
    digit_check("hold_r_ones", 0, 1);

    pulse(1, 0);
    repeat (3) @(negedge clk);
    chk("win_game_over", game_over, 1);
    chk("win_winner", winner, 2'b01);
    pulse(1, 0);
    repeat (3) @(negedge clk);
    chk("model_left_frozen", m_l, 11);
    digit_check("over_l_ones", 2, 1);
    digit_check("over_l_tens", 3, 1);

    @(negedge clk); clear = 1; score_r = 1;
    @(negedge clk); clear = 0; score_r = 0;
    repeat (3) @(negedge clk);
    chk("clr_game_over", game_over, 0);
    chk("clr_winner", winner, 0);
    chk("model_clr_right", m_r, 0);
    digit_check("clr_r_ones", 0, 0);
    digit_check("clr_l_tens", 3, 0);

    repeat (10) pulse(1, 1);
    repeat (2) @(negedge clk);
    chk("both10_game_over", game_over, 0);
    pulse(1, 1);
    repeat (3) @(negedge clk);
    chk("both_game_over", game_over, 1);
    chk("both_winner", winner, 2'b11);
    digit_check("both_l_tens", 3, 1);
    digit_check("both_r_ones", 0, 1);

    @(negedge clk); #2;
    rst_n = 1'b0; score_r = 1;
    #1;
    chk("async_tog", tog, 0);
    chk("async_num", num, 0);
    chk("async_game_over", game_over, 0);
    chk("async_winner", winner, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) @(negedge clk);
    score_r = 0;
    repeat (4) @(negedge clk);
    chk("model_held_at_release", m_r, 0);
    digit_check("held_r_ones", 0, 0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
